// File: rtl/pll_drp_if.sv
// DRP access bus between a configuration master and the PLL register bank.
// Master drives address/strobe/data, slave returns read data and DRDY.
interface pll_drp_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DADDR, DEN, DWE, DI,
    input  DO, DRDY
  );

  modport slave (
    input  DADDR, DEN, DWE, DI,
    output DO, DRDY
  );
endinterface

// File: rtl/pll_drp.sv
// PLL/MMCM DRP register bank with 7-series ClkReg1/ClkReg2/DivReg decode.
// Optional PLL_DRP_WRITE_LOCK_EN: writes only land while PLL_RST is high.
module pll_drp #(
  parameter int CHANNELS     = 6,
  parameter int DRDY_LATENCY = 3
) (
  input  logic                    DCLK,
  input  logic                    RST_N,
  pll_drp_if.slave                drp,
  input  logic                    PLL_RST,
  output logic                    DRP_ERR,
  output logic                    CFG_UPDATE,
  output logic [8*CHANNELS-1:0]   CLKOUT_DIVIDE,
  output logic [8*CHANNELS-1:0]   CLKOUT_HIGH_HALF,
  output logic [9*CHANNELS-1:0]   CLKOUT_PHASE,
  output logic [7:0]              CLKFBOUT_MULT,
  output logic [7:0]              DIVCLK_DIVIDE
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAT  = 4'(DRDY_LATENCY);
  localparam bit         FAST = (DRDY_LATENCY == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [6:0]  a_addr;
  logic        a_we;
  logic [15:0] a_di;
  logic        pend;

  logic [15:0] r1 [CHANNELS];
  logic [7:0]  r2 [CHANNELS];
  logic [15:0] fb1;
  logic [7:0]  fb2;
  logic [13:0] dv;

  logic [6:0]  acc_addr;
  logic        acc_we;
  logic [15:0] acc_di;
  logic        acc_lock;
  logic        fire;
  logic        mapped;
  logic        wr_ok;
  logic [15:0] rdata;
  logic [15:0] wmask;

  function automatic logic [7:0] len(
    input logic [5:0] v
  );
    return (v == 6'd0) ? 8'd64 : {2'b00, v};
  endfunction

  function automatic logic [7:0] divide(
    input logic [5:0] h,
    input logic [5:0] l,
    input logic       nc
  );
    return nc ? 8'd1 : len(h) + len(l);
  endfunction

  function automatic logic [7:0] half(
    input logic [5:0] h,
    input logic       e,
    input logic       nc
  );
    return nc ? 8'd1 : (len(h) << 1) + {7'd0, e};
  endfunction

  // With latency 1 the completing edge is the accepting edge,
  // so the access is taken straight from the bus.
  always_comb begin
    if (state == IDLE) begin
      acc_addr = drp.DADDR;
      acc_we   = drp.DWE;
      acc_di   = drp.DI;
    end else begin
      acc_addr = a_addr;
      acc_we   = a_we;
      acc_di   = a_di;
    end
  end

`ifdef PLL_DRP_WRITE_LOCK_EN
  logic a_lock;
  assign acc_lock = (state == IDLE) ? PLL_RST : a_lock;
  always_ff @(posedge DCLK) begin
    if (!RST_N)
      a_lock <= 1'b0;
    else if (state == IDLE && drp.DEN)
      a_lock <= PLL_RST;
  end
`else
  logic unused_pll_rst;
  assign acc_lock       = 1'b1;
  assign unused_pll_rst = PLL_RST;
`endif

  always_comb begin
    rdata  = '0;
    wmask  = '0;
    mapped = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (acc_addr == 7'(8 + 2*i)) begin
        rdata  = r1[i];
        wmask  = 16'hFFFF;
        mapped = 1'b1;
      end
      if (acc_addr == 7'(9 + 2*i)) begin
        rdata  = {8'h00, r2[i]};
        wmask  = 16'h00FF;
        mapped = 1'b1;
      end
    end
    case (acc_addr)
      7'h14: begin
        rdata  = fb1;
        wmask  = 16'hFFFF;
        mapped = 1'b1;
      end
      7'h15: begin
        rdata  = {8'h00, fb2};
        wmask  = 16'h00FF;
        mapped = 1'b1;
      end
      7'h16: begin
        rdata  = {2'b00, dv};
        wmask  = 16'h3FFF;
        mapped = 1'b1;
      end
      default: ;
    endcase
  end

  assign fire  = FAST ? (state == IDLE && drp.DEN)
                      : (state == BUSY && cnt == 4'd2);
  assign wr_ok = fire && acc_we && mapped && acc_lock;

  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      a_addr     <= '0;
      a_we       <= 1'b0;
      a_di       <= '0;
      pend       <= 1'b0;
      drp.DRDY   <= 1'b0;
      drp.DO     <= '0;
      DRP_ERR    <= 1'b0;
      CFG_UPDATE <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r1[i] <= 16'h0041;
        r2[i] <= 8'h00;
      end
      fb1 <= 16'h0041;
      fb2 <= 8'h00;
      dv  <= 14'h1041;
    end else begin
      drp.DRDY   <= fire;
      drp.DO     <= (fire && !acc_we) ? rdata : 16'h0000;
      pend       <= wr_ok && ((acc_di & wmask) != rdata);
      CFG_UPDATE <= pend;
      case (state)
        IDLE: if (drp.DEN) begin
          state  <= BUSY;
          cnt    <= LAT;
          a_addr <= drp.DADDR;
          a_we   <= drp.DWE;
          a_di   <= drp.DI;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (drp.DEN)
            DRP_ERR <= 1'b1;
          if (cnt == 4'd1)
            state <= IDLE;
        end
      endcase
`ifdef PLL_DRP_WRITE_LOCK_EN
      if (fire && acc_we && mapped && !acc_lock)
        DRP_ERR <= 1'b1;
`endif
      if (wr_ok) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (acc_addr == 7'(8 + 2*i))
            r1[i] <= acc_di;
          if (acc_addr == 7'(9 + 2*i))
            r2[i] <= acc_di[7:0];
        end
        if (acc_addr == 7'h14)
          fb1 <= acc_di;
        if (acc_addr == 7'h15)
          fb2 <= acc_di[7:0];
        if (acc_addr == 7'h16)
          dv <= acc_di[13:0];
      end
    end
  end

  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        CLKOUT_DIVIDE[8*i +: 8]    <= 8'd2;
        CLKOUT_HIGH_HALF[8*i +: 8] <= 8'd2;
        CLKOUT_PHASE[9*i +: 9]     <= 9'd0;
      end
      CLKFBOUT_MULT <= 8'd2;
      DIVCLK_DIVIDE <= 8'd1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        CLKOUT_DIVIDE[8*i +: 8] <=
          divide(r1[i][11:6], r1[i][5:0], r2[i][6]);
        CLKOUT_HIGH_HALF[8*i +: 8] <=
          half(r1[i][11:6], r2[i][7], r2[i][6]);
        CLKOUT_PHASE[9*i +: 9] <=
          {r2[i][5:0], r1[i][15:13]};
      end
      CLKFBOUT_MULT <= divide(fb1[11:6], fb1[5:0], fb2[6]);
      DIVCLK_DIVIDE <= divide(dv[11:6], dv[5:0], dv[12]);
    end
  end

  // Feedback phase/edge and DivReg edge are stored for readback only.
  logic unused_bits;
  assign unused_bits = ^{fb1[15:12], fb2[7], fb2[5:0], dv[13]};

endmodule

// File: doc/pll_drp.md
# pll_drp

Parametrised dynamic-reconfiguration (DRP) register bank for the simulated PLL/MMCM models. It decodes DRP reads and writes into per-channel counter registers using the 7-series ClkReg1/ClkReg2/DivReg bit layout. It also derives decoded divide, duty and phase values that the `pll` core consumes in place of its static parameters. It replaces the inert `DADDR/DI/DO/DRDY` stub with a latency-accurate handshake, a configurable channel count and error reporting.

## Interface
Parameters:
- `CHANNELS`, 6: number of CLKOUT channels, legal range 1..6.
- `DRDY_LATENCY`, 3: cycles from accepted `DEN` to `DRDY`, legal range 1..15.

Ports:
- `DCLK` input 1: DRP clock, sole clock.
- `RST_N` input 1: synchronous, active-low reset.
- `DADDR` input 7: register address.
- `DEN` input 1: access strobe, single-cycle.
- `DWE` input 1: write enable, sampled with `DEN`.
- `DI` input 16: write data, sampled with `DEN`.
- `PLL_RST` input 1: PLL reset state, high while the PLL is held in reset.
- `DO` output 16: read data, valid only while `DRDY`=1, otherwise 0.
- `DRDY` output 1: one-cycle completion pulse.
- `DRP_ERR` output 1: sticky error flag.
- `CFG_UPDATE` output 1: one-cycle pulse when any register changed.
- `CLKOUT_DIVIDE` output 8*CHANNELS: decoded divide per channel; channel i is at bits [8i+7:8i].
- `CLKOUT_HIGH_HALF` output 8*CHANNELS: high time in VCO half-periods.
- `CLKOUT_PHASE` output 9*CHANNELS: phase in 1/8 VCO periods.
- `CLKFBOUT_MULT` output 8: decoded feedback divide.
- `DIVCLK_DIVIDE` output 8: decoded input divide.

## Operation
- Address map:
  - Channel i: ClkReg1 at 0x08+2i, ClkReg2 at 0x09+2i.
  - Feedback: ClkReg1 at 0x14, ClkReg2 at 0x15.
  - DivReg: 0x16.
  - All other addresses, including channels ≥ CHANNELS, are unmapped: reads return 0x0000 and writes are discarded. Neither sets `DRP_ERR`.
- ClkReg1 fields: [15:13] PHASE_MUX, [12] reserved (stored, reads back), [11:6] HIGH, [5:0] LOW.
- ClkReg2 fields: [7] EDGE, [6] NO_COUNT, [5:0] DELAY. Bits [15:8] read back 0.
- DivReg fields: [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW. Other bits read back 0.
- Decoding, for every counter:
  - A field value of 0 in HIGH or LOW means 64.
  - DIVIDE = NO_COUNT ? 1 : HIGH+LOW, giving a range of 1..128.
  - HIGH_HALF = NO_COUNT ? 1 : 2*HIGH+EDGE.
  - PHASE = 8*DELAY+PHASE_MUX, giving 0..511.
  - All decoded outputs are registered.
- Reset values:
  - Every channel and the feedback counter: HIGH=1, LOW=1, all other fields 0. This decodes to divide 2, high_half 2, phase 0.
  - DivReg: NO_COUNT=1, HIGH=1, LOW=1, so DIVCLK_DIVIDE=1.
  - `DO`=0, `DRDY`=0, `DRP_ERR`=0, `CFG_UPDATE`=0.
- Handshake FSM:
  - States IDLE and BUSY.
  - IDLE→BUSY on `DEN`=1. The FSM latches `DADDR`, `DWE` and `DI`, and loads the latency counter with `DRDY_LATENCY`.
  - BUSY decrements the counter. At count 1 it asserts `DRDY` for one cycle and returns to IDLE.
  - On a write, the register updates in the `DRDY` cycle. Decoded outputs update one cycle later. `CFG_UPDATE` pulses in that same later cycle, only if the stored value differs.
  - On a read, `DO` carries the register value as it stands in the `DRDY` cycle.
  - `DEN` while BUSY, including the `DRDY` cycle: the access is ignored and `DRP_ERR` is set.
  - `DEN` in the cycle after `DRDY` is accepted normally.
- `DRP_ERR` clears only on reset.
- `RST_N` low mid-transaction: the FSM returns to IDLE, no `DRDY` is issued, and all registers return to their reset values.

## Timing
- An accepted `DEN` at cycle 0 gives `DRDY` at cycle `DRDY_LATENCY`. For a write, decoded outputs and `CFG_UPDATE` follow at `DRDY_LATENCY`+1.
- Minimum back-to-back access spacing is `DRDY_LATENCY`+1 cycles.
- All outputs change only on the rising edge of `DCLK`. There are no combinational paths from inputs to outputs.

## Configuration
- `PLL_DRP_WRITE_LOCK_EN` defined:
  - Writes to mapped addresses are applied only if `PLL_RST`=1 in the `DEN` cycle.
  - Otherwise the handshake still completes with `DRDY`, but the registers are unchanged, `CFG_UPDATE` does not pulse, and `DRP_ERR` is set.
  - Reads are unaffected.
- Macro undefined: `PLL_RST` is ignored and writes are always applied.

## Test plan
- Reset, then read 0x08 → `DRDY` at cycle 3, `DO`=0x0041. `CLKOUT_DIVIDE`[7:0]=2 and `DIVCLK_DIVIDE`=1.
- Write 0x08=0x0105 (HIGH=4, LOW=5) and 0x09=0x0083 (EDGE=1, DELAY=3) → divide 9, high_half 9, phase 24 on channel 0. `CFG_UPDATE` pulses once per write.
- Write 0x14=0x0000 → `CLKFBOUT_MULT`=128. Then write 0x15=0x0040 (NO_COUNT=1) → `CLKFBOUT_MULT`=1.
- Issue `DEN` at cycle 0 and again at cycle 1 → one `DRDY` at cycle 3, second access dropped, `DRP_ERR`=1. Pulse `RST_N` low → `DRP_ERR`=0.
- With CHANNELS=2, write 0x0C=0xFFFF then read it → `DO`=0x0000, no `CFG_UPDATE`, `DRP_ERR`=0.
- With `PLL_DRP_WRITE_LOCK_EN` and `PLL_RST`=0, write 0x08 → `DRDY`, register unchanged, `DRP_ERR`=1. With `PLL_RST`=1 the same write is applied.
